// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter between a single-cycle requester (A) and a multi-cycle completion (B),
// with a pending-destination scoreboard and read-hazard stall. Define RF_WB_RR_EN for round-robin.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_waddr,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        stall,
  output logic        RegWrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pending
);

  logic        regwrite_q, regwrite_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pending_q, pending_d;
  logic        a_elig, b_elig;
  logic        grant_a, grant_b;

  // A must not overtake an outstanding B result to the same register.
  assign a_elig = a_valid && !((a_waddr != 5'd0) && pending_q[a_waddr]);
  assign b_elig = b_valid;

`ifdef RF_WB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    grant_a = a_elig && (!b_elig || !ptr_q);
    grant_b = b_elig && (!a_elig || ptr_q);
    ptr_d   = ptr_q;
    if (a_ready)      ptr_d = 1'b1;
    else if (b_ready) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_a = a_elig;
    grant_b = b_elig && !a_elig;
  end
`endif

  assign a_ready = rst && grant_a;
  assign b_ready = rst && grant_b;

  always_comb begin
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (a_ready) begin
      regwrite_d = (a_waddr != 5'd0);
      waddr_d    = a_waddr;
      wdata_d    = a_wdata;
    end else if (b_ready) begin
      regwrite_d = (b_waddr != 5'd0);
      waddr_d    = b_waddr;
      wdata_d    = b_wdata;
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (b_ready) pending_d[b_waddr] = 1'b0;
    if (iss_valid && (iss_waddr != 5'd0)) pending_d[iss_waddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite_q <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      pending_q  <= 32'd0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    stall = 1'b0;
    if ((raddr1 != 5'd0) && (pending_q[raddr1] || (regwrite_q && (waddr_q == raddr1))))
      stall = 1'b1;
    if ((raddr2 != 5'd0) && (pending_q[raddr2] || (regwrite_q && (waddr_q == raddr2))))
      stall = 1'b1;
  end

  assign RegWrite = regwrite_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign pending  = pending_q;

endmodule
